cmp_wide_seq: RTL and testbench



---
 rtl/cmp_wide_seq.sv | 139 +++++++++++++
 tb/tb_cmp_wide_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_wide_seq.sv
// cmp_wide_seq: wide unsigned magnitude compare sequenced MSB chunk first
// through one narrow W-bit comparator.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   i_vld/o_rdy       operand request handshake (i_a, i_b are N*W bits)
//   o_res_vld/i_res_rdy  result handshake
//   o_eq/o_gt/o_lt    registered one-hot result, valid while o_res_vld
//   o_busy            high while chunks are being compared

module cmp #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_eq,
   output logic         o_gt,
   output logic         o_lt
);
   assign o_eq = (i_a == i_b);
   assign o_gt = (i_a > i_b);
   assign o_lt = (i_a < i_b);
endmodule

module cmp_wide_seq #(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_vld,
   input  logic [N*W-1:0] i_a,
   input  logic [N*W-1:0] i_b,
   output logic         o_rdy,
   output logic         o_res_vld,
   input  logic         i_res_rdy,
   output logic         o_eq,
   output logic         o_gt,
   output logic         o_lt,
   output logic         o_busy
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N*W-1:0]  a_q, a_d;
   logic [N*W-1:0]  b_q, b_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            eq_q, eq_d;
   logic            gt_q, gt_d;
   logic            lt_q, lt_d;

   logic [W-1:0]    a_chunk;
   logic [W-1:0]    b_chunk;
   logic            c_eq, c_gt, c_lt;

   assign a_chunk = a_q[int'(idx_q)*W +: W];
   assign b_chunk = b_q[int'(idx_q)*W +: W];

   cmp #(.W(W)) u_cmp (
      .i_a  (a_chunk),
      .i_b  (b_chunk),
      .o_eq (c_eq),
      .o_gt (c_gt),
      .o_lt (c_lt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_vld) begin
               a_d     = i_a;
               b_d     = i_b;
               idx_d   = IW'(N - 1);
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            // First unequal chunk decides; idx==0 check wins over decrement.
            if (!c_eq) begin
               eq_d    = 1'b0;
               gt_d    = c_gt;
               lt_d    = c_lt;
               state_d = S_DONE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         S_DONE: begin
            if (i_res_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   assign o_rdy     = (state_q == S_IDLE);
   assign o_busy    = (state_q == S_CMP);
   assign o_res_vld = (state_q == S_DONE);
   assign o_eq      = eq_q;
   assign o_gt      = gt_q;
   assign o_lt      = lt_q;
endmodule

// File: tb/tb_cmp_wide_seq.sv
// tb_cmp_wide_seq: randomized and directed checks of cmp_wide_seq
// (N=4,W=8 main instance; N=1,W=8 instance for back-to-back).

module tb_cmp_wide_seq;
   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          i_vld, i_res_rdy;
   logic [31:0]   i_a, i_b;
   logic          o_rdy, o_res_vld, o_eq, o_gt, o_lt, o_busy;

   logic          s_vld, s_res_rdy;
   logic [7:0]    s_a, s_b;
   logic          s_rdy, s_res_vld, s_eq, s_gt, s_lt, s_busy;

   int n_chk = 0;
   int n_fail = 0;

   cmp_wide_seq #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .i_vld(i_vld), .i_a(i_a), .i_b(i_b),
      .o_rdy(o_rdy), .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy),
      .o_eq(o_eq), .o_gt(o_gt), .o_lt(o_lt), .o_busy(o_busy)
   );

   cmp_wide_seq #(.W(8), .N(1)) dut1 (
      .clk(clk), .rst(rst), .i_vld(s_vld), .i_a(s_a), .i_b(s_b),
      .o_rdy(s_rdy), .o_res_vld(s_res_vld), .i_res_rdy(s_res_rdy),
      .o_eq(s_eq), .o_gt(s_gt), .o_lt(s_lt), .o_busy(s_busy)
   );

   // Reference: one-hot {eq,gt,lt} from plain unsigned compare.
   function automatic logic [2:0] exp_flags(input logic [31:0] a,
                                            input logic [31:0] b);
      if (a > b) return 3'b010;
      if (a < b) return 3'b001;
      return 3'b100;
   endfunction

   // Reference: CMP cycles = N - (index of highest differing byte).
   function automatic int exp_k(input logic [31:0] a, input logic [31:0] b);
      for (int j = N - 1; j >= 0; j--)
         if (a[j*W +: W] != b[j*W +: W]) return N - j;
      return N;
   endfunction

   // Drives one request from a negedge; returns cycles to o_res_vld
   // (-1 on timeout), the flags then, and how many cycles o_busy was high.
   task automatic run4(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [2:0] fl,
                       output int bn);
      i_a = a;
      i_b = b;
      i_vld = 1'b1;
      @(posedge clk);
      #1;
      i_vld = 1'b0;
      i_a = $urandom;
      i_b = $urandom;
      lat = -1;
      bn = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (o_busy) bn++;
         if (o_res_vld) begin
            lat = c;
            break;
         end
      end
      fl = {o_eq, o_gt, o_lt};
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({o_rdy, o_res_vld, o_busy, o_eq, o_gt, o_lt} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_state: got %b want 100000",
                  {o_rdy, o_res_vld, o_busy, o_eq, o_gt, o_lt});
      end
      n_chk++;
      if ({s_rdy, s_res_vld, s_busy, s_eq, s_gt, s_lt} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_state_n1: got %b want 100000",
                  {s_rdy, s_res_vld, s_busy, s_eq, s_gt, s_lt});
      end
   endtask

   task automatic test_top_chunk;
      int lat, bn;
      logic [2:0] fl;
      i_res_rdy = 1'b1;
      run4(32'h8000_0000, 32'h7FFF_FFFF, lat, fl, bn);
      n_chk++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL top_latency: got %0d want 2", lat);
      end
      n_chk++;
      if (fl !== 3'b010) begin
         n_fail++; $display("FAIL top_flags: got %b want 010", fl);
      end
      n_chk++;
      if (bn !== 1) begin
         n_fail++; $display("FAIL top_busy: got %0d want 1", bn);
      end
      @(negedge clk);
      i_res_rdy = 1'b0;
      n_chk++;
      if ({o_rdy, o_res_vld} !== 2'b10) begin
         n_fail++;
         $display("FAIL top_release: got %b want 10", {o_rdy, o_res_vld});
      end
   endtask

   task automatic test_bottom_chunk;
      int lat, bn;
      logic [2:0] fl;
      run4(32'h1234_5677, 32'h1234_5678, lat, fl, bn);
      n_chk++;
      if (lat !== 5 || fl !== 3'b001 || bn !== 4) begin
         n_fail++;
         $display("FAIL bottom: got lat=%0d fl=%b busy=%0d want 5 001 4",
                  lat, fl, bn);
      end
      i_res_rdy = 1'b1;
      @(negedge clk);
      i_res_rdy = 1'b0;
   endtask

   task automatic test_equal;
      int lat, bn;
      logic [2:0] fl;
      logic [31:0] v [2];
      v[0] = 32'hDEAD_BEEF;
      v[1] = 32'h0;
      for (int i = 0; i < 2; i++) begin
         run4(v[i], v[i], lat, fl, bn);
         n_chk++;
         if (lat !== 5 || fl !== 3'b100 || bn !== 4) begin
            n_fail++;
            $display("FAIL equal_%0d: got lat=%0d fl=%b busy=%0d want 5 100 4",
                     i, lat, fl, bn);
         end
         i_res_rdy = 1'b1;
         @(negedge clk);
         i_res_rdy = 1'b0;
      end
   endtask

   task automatic test_random;
      int lat, bn, j, ek;
      logic [2:0] fl, ef;
      logic [31:0] a, b;
      for (int it = 0; it < 40; it++) begin
         a = $urandom;
         b = $urandom;
         j = $urandom_range(0, 4);
         for (int c = 0; c < N; c++)
            if (c > j || j == 4) b[c*W +: W] = a[c*W +: W];
         ek = exp_k(a, b);
         ef = exp_flags(a, b);
         run4(a, b, lat, fl, bn);
         n_chk++;
         if (lat !== ek + 1 || fl !== ef || bn !== ek) begin
            n_fail++;
            $display("FAIL rand_%0d a=%h b=%h: got lat=%0d fl=%b busy=%0d want %0d %b %0d",
                     it, a, b, lat, fl, bn, ek + 1, ef, ek);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         i_res_rdy = 1'b1;
         @(negedge clk);
         i_res_rdy = 1'b0;
         n_chk++;
         if ({o_rdy, o_res_vld, o_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rand_release_%0d: got %b want 100",
                     it, {o_rdy, o_res_vld, o_busy});
         end
      end
   endtask

   task automatic test_backpressure;
      int lat;
      logic [2:0] fl;
      i_a = 32'h1122_3344;
      i_b = 32'h1122_3345;
      i_vld = 1'b1;
      i_res_rdy = 1'b0;
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         i_a = $urandom;
         i_b = $urandom;
         i_vld = $urandom_range(0, 1);
         if (o_res_vld) begin
            lat = c;
            break;
         end
      end
      n_chk++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL bp_latency: got %0d want 5", lat);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         i_a = $urandom;
         i_b = $urandom;
         i_vld = $urandom_range(0, 1);
         fl = {o_eq, o_gt, o_lt};
         n_chk++;
         if ({o_res_vld, o_rdy, o_busy} !== 3'b100 || fl !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got vld/rdy/busy=%b fl=%b want 100 001",
                     c, {o_res_vld, o_rdy, o_busy}, fl);
         end
      end
      i_vld = 1'b0;
      i_res_rdy = 1'b1;
      @(negedge clk);
      i_res_rdy = 1'b0;
      n_chk++;
      if ({o_rdy, o_res_vld, o_busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL bp_release: got %b want 100", {o_rdy, o_res_vld, o_busy});
      end
      @(negedge clk);
      n_chk++;
      if ({o_rdy, o_busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_no_accept: got %b want 10", {o_rdy, o_busy});
      end
   endtask

   task automatic test_mid_reset;
      int lat, bn, seen;
      logic [2:0] fl;
      i_a = 32'hCAFE_F00D;
      i_b = 32'hCAFE_F00D;
      i_vld = 1'b1;
      @(posedge clk);
      #1;
      i_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({o_rdy, o_res_vld, o_busy, o_eq, o_gt, o_lt} !== 6'b100000) begin
         n_fail++;
         $display("FAIL rst_mid_cmp: got %b want 100000",
                  {o_rdy, o_res_vld, o_busy, o_eq, o_gt, o_lt});
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (o_res_vld || o_busy) seen++;
      end
      n_chk++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL rst_no_result: got %0d active cycles want 0", seen);
      end
      run4(32'h0000_0001, 32'h0000_0002, lat, fl, bn);
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({o_rdy, o_res_vld, o_eq, o_gt, o_lt} !== 5'b10000) begin
         n_fail++;
         $display("FAIL rst_in_done: got %b want 10000",
                  {o_rdy, o_res_vld, o_eq, o_gt, o_lt});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      s_a = 8'h05;
      s_b = 8'h09;
      s_vld = 1'b1;
      s_res_rdy = 1'b1;
      @(posedge clk);
      #1;
      s_a = 8'hFF;
      s_b = 8'hFF;
      @(negedge clk);
      n_chk++;
      if ({s_busy, s_res_vld} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_c1: got %b want 10", {s_busy, s_res_vld});
      end
      @(negedge clk);
      n_chk++;
      if ({s_res_vld, s_eq, s_gt, s_lt} !== 4'b1001) begin
         n_fail++;
         $display("FAIL b2b_first: got %b want 1001", {s_res_vld, s_eq, s_gt, s_lt});
      end
      @(negedge clk);
      n_chk++;
      if ({s_rdy, s_res_vld} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_idle: got %b want 10", {s_rdy, s_res_vld});
      end
      @(negedge clk);
      n_chk++;
      if ({s_busy, s_rdy} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_accept2: got %b want 10", {s_busy, s_rdy});
      end
      s_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({s_res_vld, s_eq, s_gt, s_lt} !== 4'b1100) begin
         n_fail++;
         $display("FAIL b2b_second: got %b want 1100", {s_res_vld, s_eq, s_gt, s_lt});
      end
      @(negedge clk);
      s_res_rdy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_vld = 1'b0;
      i_res_rdy = 1'b0;
      i_a = '0;
      i_b = '0;
      s_vld = 1'b0;
      s_res_rdy = 1'b0;
      s_a = '0;
      s_b = '0;
      repeat (2) @(negedge clk);
      test_reset;
      test_top_chunk;
      test_bottom_chunk;
      test_equal;
      test_backpressure;
      test_random;
      test_mid_reset;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
